mmio_bridge_n: RTL and testbench
================================

# mmio_bridge_n

Parametrised memory-mapped I/O bridge between the CPU data port and up to six peripherals (counter, screen board, seg7 and successors). It registers each CPU access, decodes the page to a one-hot device select, and holds the access until the device signals ready, with a bounded timeout. It also reports an error for unmapped pages and aggregates device interrupts through latched pending and mask registers onto `hw_int`. It sits between the CPU data-memory stage and the device layer.

## Interface
- `N_DEV`, 3: number of device slots, 1..6.
- `PAGE_LSB`, 8: address bits [31:PAGE_LSB] select the page.
- `BASE_PAGE`, 'h7F: page of device 0; device k occupies page BASE_PAGE+k.
- `CTRL_PAGE`, 'h7E: page of the bridge's own control registers.
- `TIMEOUT`, 16: maximum ACCESS cycles before a bus error, ≥1.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: access request; held stable until `cpu_ack`.
- `cpu_addr` in 30: word address [31:2].
- `cpu_wdata` in 32: write data.
- `cpu_be` in 4: byte enables.
- `cpu_we` in 1: 1 = write.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: read data, valid with `cpu_ack`.
- `cpu_err` out 1: bus error, valid with `cpu_ack`.
- `dev_sel` out N_DEV: one-hot device select.
- `dev_we` out 1: write strobe, qualified by `dev_sel`.
- `dev_addr` out PAGE_LSB-2: in-page word offset.
- `dev_wdata` out 32: latched write data.
- `dev_be` out 4: latched byte enables.
- `dev_rdata` in N_DEV*32: device k read data at [32k+31:32k].
- `dev_ready` in N_DEV: device k completes the access in this cycle.
- `dev_irq` in N_DEV: level interrupt request from each device.
- `hw_int` out 6: [7:2]; bit 2+k = pend[k] & mask[k]; bits above N_DEV read 0.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** on `cpu_req` the bridge latches addr, wdata, be and we, then decodes the page.
  - Device page: go to ACCESS.
  - CTRL_PAGE: perform the register access, then go to RESP.
  - Any other page: set error, capture ERR_ADDR, go to RESP.
- **ACCESS:**
  - `dev_sel[k]` and `dev_we` are held from the latched request.
  - `dev_ready[k]=1` captures that device's rdata, clears the error and goes to RESP. The device commits a write in that same cycle.
  - If ready is still low when the timeout counter reaches TIMEOUT-1, the bridge sets the error, captures ERR_ADDR and goes to RESP.
  - Ready arriving on the final cycle takes priority over the timeout.
- **RESP:** `cpu_ack=1` for one cycle, then IDLE. `cpu_req` is ignored during RESP, so the CPU drops or replaces its request after sampling ack.
- On error, `cpu_rdata` is 0.
- **Control registers** (word offsets). Only `cpu_be[0]` gates writes; unused bits read 0.
  - 0x0 IRQ_PEND: read pending; writing 1 to a bit clears it (write-1-to-clear).
  - 0x4 IRQ_MASK: read/write, N_DEV bits.
  - 0x8 ERR_ADDR: read-only; byte address {addr,2'b00} of the last error.
  - Other offsets read 0 with no error.
- **Interrupts:**
  - A rising edge of `dev_irq[k]` (registered previous value) sets pend[k].
  - If a W1C clear and an edge land in the same cycle, set wins.
  - Mask does not affect latching, only `hw_int`.

## Timing
- Reset values: state IDLE; all outputs 0; pend, mask, ERR_ADDR, previous-irq register and timeout counter 0.
- A `dev_irq` high at reset release counts as an edge and sets pending on the first clock.
- Latency in cycles from `cpu_req` sampled in IDLE (cycle 0):
  - Control or unmapped access: `cpu_ack` in cycle 1.
  - Device with ready in its first ACCESS cycle: `dev_sel` in cycle 1, ack in cycle 2.
  - Device timeout: ack in cycle TIMEOUT+1.
- Timeout counter width is clog2(TIMEOUT+1); it clears on entering ACCESS.
- `hw_int` is registered logic from pend and mask. An edge at cycle n appears on `hw_int` at cycle n+1.
- Reset asserted mid-ACCESS drops `dev_sel` immediately and asynchronously; no ack is issued.

## Structure
- Package `mmio_bridge_pkg` holds:
  - the state enum;
  - control offsets CTRL_PEND=0, CTRL_MASK=1, CTRL_ERR=2 (word);
  - default page constants.
- Sub-module `irq_ctrl`: edge detect, pend/mask/W1C logic, `hw_int` generation; parameter N_DEV.
- Top: FSM, request latch, decode, read mux, timeout.

## Test plan
- Read 0x7F00 with device 0 ready in its first ACCESS cycle and rdata=0x1234 -> ack in cycle 2, rdata 0x1234, err 0, dev_sel=001.
- Write 0x8004, data 0xAB, be=0001, device 1 ready after 3 cycles -> dev_we and dev_sel=010 held for 3 cycles, dev_addr=1, ack on the following cycle.
- Device 2 never ready, TIMEOUT=16 -> ack at cycle 17, err 1, rdata 0; ERR_ADDR reads 0x8100.
- Read 0x9000 (unmapped) -> ack cycle 1, err 1; ERR_ADDR = 0x9000.
- Pulse dev_irq[0] with mask=0 -> PEND=1, hw_int=0; write MASK=1 -> hw_int[2]=1; write PEND=1 -> hw_int=0.
- Assert rst_n=0 during ACCESS -> dev_sel=0 and all outputs 0 asynchronously; the next request completes normally.

Source files
------------

// File: rtl/mmio_bridge_pkg.sv
// rtl/mmio_bridge_pkg.sv - shared types and constants for the MMIO bridge
package mmio_bridge_pkg;

  // Bridge sequencing: accept a request, wait on a device, present the response
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Word offsets of the bridge's own registers inside CTRL_PAGE
  localparam int CTRL_PEND = 0;
  localparam int CTRL_MASK = 1;
  localparam int CTRL_ERR  = 2;

  // Default memory map
  localparam int DEF_PAGE_LSB  = 8;
  localparam int DEF_BASE_PAGE = 'h7F;
  localparam int DEF_CTRL_PAGE = 'h7E;
  localparam int DEF_TIMEOUT   = 16;

endpackage

// File: rtl/mmio_bridge_n_irq.sv
// rtl/mmio_bridge_n_irq.sv - interrupt edge latch, mask and hw_int aggregation
module irq_ctrl #(
  parameter int N_DEV = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_DEV-1:0] i_irq,
  input  logic [N_DEV-1:0] i_pend_clr,
  input  logic             i_mask_we,
  input  logic [N_DEV-1:0] i_mask_wdata,
  output logic [N_DEV-1:0] o_pend,
  output logic [N_DEV-1:0] o_mask,
  output logic [5:0]       o_hw_int
);

  logic [N_DEV-1:0] r_irq_prev;
  logic [N_DEV-1:0] r_pend;
  logic [N_DEV-1:0] r_mask;
  logic [5:0]       r_hw_int;
  logic [N_DEV-1:0] w_edge;
  logic [N_DEV-1:0] w_pend_nxt;
  logic [N_DEV-1:0] w_mask_nxt;
  logic [5:0]       w_hw_int;

  // Next pending/mask state; a new edge beats a simultaneous write-1-to-clear
  always_comb begin
    w_edge     = i_irq & ~r_irq_prev;
    w_pend_nxt = (r_pend & ~i_pend_clr) | w_edge;
    w_mask_nxt = i_mask_we ? i_mask_wdata : r_mask;
    w_hw_int   = '0;
    w_hw_int[N_DEV-1:0] = w_pend_nxt & w_mask_nxt;
  end

  // Register edge history, pending, mask and the masked interrupt lines
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq_prev <= '0;
      r_pend     <= '0;
      r_mask     <= '0;
      r_hw_int   <= '0;
    end else begin
      r_irq_prev <= i_irq;
      r_pend     <= w_pend_nxt;
      r_mask     <= w_mask_nxt;
      r_hw_int   <= w_hw_int;
    end
  end

  assign o_pend   = r_pend;
  assign o_mask   = r_mask;
  assign o_hw_int = r_hw_int;

endmodule

// File: rtl/mmio_bridge_n.sv
// rtl/mmio_bridge_n.sv - CPU data port to device bridge with decode, timeout and interrupt registers
module mmio_bridge_n
  import mmio_bridge_pkg::*;
#(
  parameter int N_DEV     = 3,
  parameter int PAGE_LSB  = DEF_PAGE_LSB,
  parameter int BASE_PAGE = DEF_BASE_PAGE,
  parameter int CTRL_PAGE = DEF_CTRL_PAGE,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cpu_req,
  input  logic [29:0]           i_cpu_addr,
  input  logic [31:0]           i_cpu_wdata,
  input  logic [3:0]            i_cpu_be,
  input  logic                  i_cpu_we,
  output logic                  o_cpu_ack,
  output logic [31:0]           o_cpu_rdata,
  output logic                  o_cpu_err,
  output logic [N_DEV-1:0]      o_dev_sel,
  output logic                  o_dev_we,
  output logic [PAGE_LSB-3:0]   o_dev_addr,
  output logic [31:0]           o_dev_wdata,
  output logic [3:0]            o_dev_be,
  input  logic [N_DEV*32-1:0]   i_dev_rdata,
  input  logic [N_DEV-1:0]      i_dev_ready,
  input  logic [N_DEV-1:0]      i_dev_irq,
  output logic [5:0]            o_hw_int
);

  localparam int PAGE_W = 32 - PAGE_LSB;
  localparam int OFF_W  = PAGE_LSB - 2;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [PAGE_W-1:0] BASE_P = PAGE_W'(BASE_PAGE);
  localparam logic [PAGE_W-1:0] CTRL_P = PAGE_W'(CTRL_PAGE);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [29:0]        r_addr;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_err_addr;

  logic [PAGE_W-1:0]  w_page;
  logic [OFF_W-1:0]   w_off;
  logic [PAGE_W-1:0]  w_rel;
  logic               w_dev_hit;
  logic               w_ctrl_hit;
  logic [N_DEV-1:0]   w_onehot;
  logic               w_ready_hit;
  logic [31:0]        w_dev_rdata;
  logic               w_timeout;
  logic [31:0]        w_ctrl_rdata;
  logic               w_ctrl_wr;
  logic [N_DEV-1:0]   w_pend_clr;
  logic               w_mask_we;
  logic [N_DEV-1:0]   w_pend;
  logic [N_DEV-1:0]   w_mask;

  logic               w_load;
  logic               w_resp;
  logic               w_resp_err;
  logic [31:0]        w_resp_rdata;
  logic               w_err_cap;
  logic [31:0]        w_err_addr;

  // Page decode of the incoming CPU address into device / control / unmapped
  always_comb begin
    w_page     = i_cpu_addr[29:OFF_W];
    w_off      = i_cpu_addr[OFF_W-1:0];
    w_rel      = w_page - BASE_P;
    w_dev_hit  = (w_page >= BASE_P) && (w_rel < PAGE_W'(N_DEV));
    w_ctrl_hit = (w_page == CTRL_P);
    w_onehot   = '0;
    for (int k = 0; k < N_DEV; k++) begin
      w_onehot[k] = (w_rel == PAGE_W'(k));
    end
  end

  // Selected device's ready and read data, plus the timeout condition
  always_comb begin
    w_ready_hit = |(i_dev_ready & o_dev_sel);
    w_dev_rdata = '0;
    for (int k = 0; k < N_DEV; k++) begin
      if (o_dev_sel[k]) begin
        w_dev_rdata = w_dev_rdata | i_dev_rdata[k*32 +: 32];
      end
    end
    w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
  end

  // Control register read mux and write strobes, taken straight from the IDLE request
  always_comb begin
    unique case (w_off)
      OFF_W'(CTRL_PEND): w_ctrl_rdata = 32'(w_pend);
      OFF_W'(CTRL_MASK): w_ctrl_rdata = 32'(w_mask);
      OFF_W'(CTRL_ERR):  w_ctrl_rdata = r_err_addr;
      default:           w_ctrl_rdata = '0;
    endcase
    w_ctrl_wr  = (r_state == ST_IDLE) && i_cpu_req && w_ctrl_hit && i_cpu_we && i_cpu_be[0];
    w_pend_clr = (w_ctrl_wr && (w_off == OFF_W'(CTRL_PEND))) ? i_cpu_wdata[N_DEV-1:0] : '0;
    w_mask_we  = w_ctrl_wr && (w_off == OFF_W'(CTRL_MASK));
  end

  // Next-state and response selection; ready on the last ACCESS cycle beats the timeout
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_resp       = 1'b0;
    w_resp_err   = 1'b0;
    w_resp_rdata = '0;
    w_err_cap    = 1'b0;
    w_err_addr   = r_err_addr;
    case (r_state)
      ST_IDLE: begin
        if (i_cpu_req) begin
          w_load = 1'b1;
          if (w_dev_hit) begin
            w_state_nxt = ST_ACCESS;
          end else if (w_ctrl_hit) begin
            w_state_nxt  = ST_RESP;
            w_resp       = 1'b1;
            w_resp_rdata = w_ctrl_rdata;
          end else begin
            w_state_nxt = ST_RESP;
            w_resp      = 1'b1;
            w_resp_err  = 1'b1;
            w_err_cap   = 1'b1;
            w_err_addr  = {i_cpu_addr, 2'b00};
          end
        end
      end
      ST_ACCESS: begin
        if (w_ready_hit) begin
          w_state_nxt  = ST_RESP;
          w_resp       = 1'b1;
          w_resp_rdata = w_dev_rdata;
        end else if (w_timeout) begin
          w_state_nxt = ST_RESP;
          w_resp      = 1'b1;
          w_resp_err  = 1'b1;
          w_err_cap   = 1'b1;
          w_err_addr  = {r_addr, 2'b00};
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request latch, device strobes, timeout counter and registered CPU response
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr      <= '0;
      r_cnt       <= '0;
      r_err_addr  <= '0;
      o_cpu_ack   <= 1'b0;
      o_cpu_err   <= 1'b0;
      o_cpu_rdata <= '0;
      o_dev_sel   <= '0;
      o_dev_we    <= 1'b0;
      o_dev_addr  <= '0;
      o_dev_wdata <= '0;
      o_dev_be    <= '0;
    end else begin
      o_cpu_ack   <= w_resp;
      o_cpu_err   <= w_resp_err;
      o_cpu_rdata <= w_resp_rdata;
      if (w_load) begin
        r_addr      <= i_cpu_addr;
        o_dev_addr  <= w_off;
        o_dev_wdata <= i_cpu_wdata;
        o_dev_be    <= i_cpu_be;
      end
      if (w_load && w_dev_hit) begin
        o_dev_sel <= w_onehot;
        o_dev_we  <= i_cpu_we;
        r_cnt     <= '0;
      end else if (w_resp) begin
        o_dev_sel <= '0;
        o_dev_we  <= 1'b0;
      end else if (r_state == ST_ACCESS) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_err_cap) begin
        r_err_addr <= w_err_addr;
      end
    end
  end

  irq_ctrl #(
    .N_DEV(N_DEV)
  ) u_irq (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_irq        (i_dev_irq),
    .i_pend_clr   (w_pend_clr),
    .i_mask_we    (w_mask_we),
    .i_mask_wdata (i_cpu_wdata[N_DEV-1:0]),
    .o_pend       (w_pend),
    .o_mask       (w_mask),
    .o_hw_int     (o_hw_int)
  );

endmodule

// File: tb/tb_mmio_bridge_n.sv
// tb/tb_mmio_bridge_n.sv - scoreboard bench for mmio_bridge_n
module tb_mmio_bridge_n;

  localparam int N_DEV   = 3;
  localparam int TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                i_cpu_req;
  logic [29:0]         i_cpu_addr;
  logic [31:0]         i_cpu_wdata;
  logic [3:0]          i_cpu_be;
  logic                i_cpu_we;
  logic                o_cpu_ack;
  logic [31:0]         o_cpu_rdata;
  logic                o_cpu_err;
  logic [N_DEV-1:0]    o_dev_sel;
  logic                o_dev_we;
  logic [5:0]          o_dev_addr;
  logic [31:0]         o_dev_wdata;
  logic [3:0]          o_dev_be;
  logic [N_DEV*32-1:0] i_dev_rdata;
  logic [N_DEV-1:0]    i_dev_ready;
  logic [N_DEV-1:0]    i_dev_irq;
  logic [5:0]          o_hw_int;

  mmio_bridge_n #(
    .N_DEV(N_DEV), .PAGE_LSB(8), .BASE_PAGE('h7F), .CTRL_PAGE('h7E), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cpu_req(i_cpu_req), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .i_cpu_be(i_cpu_be), .i_cpu_we(i_cpu_we),
    .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata), .o_cpu_err(o_cpu_err),
    .o_dev_sel(o_dev_sel), .o_dev_we(o_dev_we), .o_dev_addr(o_dev_addr),
    .o_dev_wdata(o_dev_wdata), .o_dev_be(o_dev_be), .i_dev_rdata(i_dev_rdata),
    .i_dev_ready(i_dev_ready), .i_dev_irq(i_dev_irq), .o_hw_int(o_hw_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
    int          lat;
    int          start;
    logic [5:0]  hw;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference state: device memories, interrupt registers, last error address
  logic [31:0]      dev_mem [N_DEV][64];
  logic [31:0]      ref_mem [N_DEV][64];
  logic [N_DEV-1:0] model_pend = '0;
  logic [N_DEV-1:0] model_mask = '0;
  logic [N_DEV-1:0] irq_prev_m = '0;
  logic [N_DEV-1:0] irq_cur = '0;
  logic [31:0]      model_err = '0;

  // Device-side expectations for the access in flight
  int               acc_cnt = 0;
  int               dev_delay = 0;
  int               exp_hold = -1;
  logic [N_DEV-1:0] exp_sel = '0;
  logic [5:0]       exp_addr = '0;
  logic             exp_we = 1'b0;
  logic [31:0]      exp_wdata = '0;
  logic [3:0]       exp_be = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Device model: checks strobes, raises ready after the chosen delay, commits writes
  always @(negedge clk) begin
    i_dev_ready = '0;
    if (o_dev_sel != '0) begin
      if (acc_cnt == 0) begin
        chk("dev_sel", 32'(o_dev_sel), 32'(exp_sel));
        chk("dev_addr", 32'(o_dev_addr), 32'(exp_addr));
        chk("dev_we", 32'(o_dev_we), 32'(exp_we));
        if (exp_we) begin
          chk("dev_wdata", o_dev_wdata, exp_wdata);
          chk("dev_be", 32'(o_dev_be), 32'(exp_be));
        end
      end
      if (acc_cnt == dev_delay) begin
        i_dev_ready = o_dev_sel;
        for (int k = 0; k < N_DEV; k++)
          if (o_dev_sel[k] && o_dev_we)
            dev_mem[k][o_dev_addr] = merge(dev_mem[k][o_dev_addr], o_dev_wdata, o_dev_be);
      end
      acc_cnt++;
    end else if (acc_cnt != 0) begin
      if (exp_hold >= 0) chk("dev_sel_hold", 32'(acc_cnt), 32'(exp_hold));
      acc_cnt = 0;
    end
    for (int k = 0; k < N_DEV; k++) i_dev_rdata[k*32 +: 32] = dev_mem[k][o_dev_addr];
  end

  // Response monitor: pops the oldest expectation on every ack
  always @(negedge clk) begin
    if (rst_n && o_cpu_ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 required no ack");
      end else begin
        m = sb.pop_front();
        chk("cpu_err", 32'(o_cpu_err), 32'(m.err));
        if (m.chk_rd) chk("cpu_rdata", o_cpu_rdata, m.rdata);
        chk("ack_latency", 32'(cyc - m.start), 32'(m.lat));
        chk("hw_int", 32'(o_hw_int), 32'(m.hw));
      end
    end
  end

  task automatic issue(input logic [31:0] baddr, input logic we, input logic [31:0] wd,
                       input logic [3:0] be, input int delay, input int hold, input exp_t e,
                       input logic [N_DEV-1:0] irq_v);
    exp_t ee;
    int   n;
    logic got;
    ee = e;
    @(negedge clk);
    ee.start = cyc;
    sb.push_back(ee);
    dev_delay   = delay;
    exp_hold    = hold;
    i_cpu_req   = 1'b1;
    i_cpu_addr  = baddr[31:2];
    i_cpu_we    = we;
    i_cpu_wdata = wd;
    i_cpu_be    = be;
    i_dev_irq   = irq_v;
    got = 1'b0;
    n = 0;
    while (!got && n < TIMEOUT + 8) begin
      @(posedge clk);
      #2;
      if (o_cpu_ack) got = 1'b1;
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: got no ack within %0d cycles required ack", TIMEOUT + 8);
      if (sb.size() > 0) void'(sb.pop_back());
    end
    @(negedge clk);
    i_cpu_req = 1'b0;
  endtask

  // Reference model of one CPU access, derived from the memory map and register rules
  task automatic do_access(input logic [31:0] baddr, input logic we, input logic [31:0] wd,
                           input logic [3:0] be, input int delay, input logic [N_DEV-1:0] irq_v);
    exp_t e;
    int page, off, k, hold;
    logic [N_DEV-1:0] rise;
    page = int'(baddr[31:8]);
    off  = int'(baddr[7:2]);
    rise = irq_v & ~irq_prev_m;
    e.err = 1'b0; e.rdata = '0; e.chk_rd = !we; e.lat = 1; e.start = 0; e.hw = '0;
    hold = -1;
    if (page >= 'h7F && page < 'h7F + N_DEV) begin
      k = page - 'h7F;
      exp_sel = '0; exp_sel[k] = 1'b1;
      exp_addr = baddr[7:2]; exp_we = we; exp_wdata = wd; exp_be = be;
      if (delay >= TIMEOUT) begin
        e.err = 1'b1; e.chk_rd = 1'b1; e.lat = TIMEOUT + 1; hold = TIMEOUT;
        model_err = {baddr[31:2], 2'b00};
      end else begin
        e.lat = delay + 2; hold = delay + 1;
        e.rdata = ref_mem[k][off];
        if (we) ref_mem[k][off] = merge(ref_mem[k][off], wd, be);
      end
    end else if (page == 'h7E) begin
      case (off)
        0: e.rdata = 32'(model_pend);
        1: e.rdata = 32'(model_mask);
        2: e.rdata = model_err;
        default: e.rdata = '0;
      endcase
      if (we && be[0]) begin
        if (off == 0) model_pend = model_pend & ~wd[N_DEV-1:0];
        if (off == 1) model_mask = wd[N_DEV-1:0];
      end
    end else begin
      e.err = 1'b1; e.chk_rd = 1'b1;
      model_err = {baddr[31:2], 2'b00};
    end
    model_pend = model_pend | rise;
    irq_prev_m = irq_v;
    irq_cur = irq_v;
    e.hw = 6'(model_pend & model_mask);
    issue(baddr, we, wd, be, delay, hold, e, irq_v);
  endtask

  task automatic set_irq(input logic [N_DEV-1:0] v);
    @(negedge clk);
    i_dev_irq = v;
    model_pend = model_pend | (v & ~irq_prev_m);
    irq_prev_m = v;
    irq_cur = v;
    @(negedge clk);
    chk("hw_int_edge", 32'(o_hw_int), 32'(6'(model_pend & model_mask)));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(o_cpu_ack), 32'd0);
    chk({tag, "_err"}, 32'(o_cpu_err), 32'd0);
    chk({tag, "_rdata"}, o_cpu_rdata, 32'd0);
    chk({tag, "_sel"}, 32'(o_dev_sel), 32'd0);
    chk({tag, "_we"}, 32'(o_dev_we), 32'd0);
    chk({tag, "_daddr"}, 32'(o_dev_addr), 32'd0);
    chk({tag, "_dwdata"}, o_dev_wdata, 32'd0);
    chk({tag, "_dbe"}, 32'(o_dev_be), 32'd0);
    chk({tag, "_hwint"}, 32'(o_hw_int), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    int sel, dly, pg;
    i_cpu_req = 1'b0; i_cpu_addr = '0; i_cpu_wdata = '0; i_cpu_be = '0; i_cpu_we = 1'b0;
    i_dev_rdata = '0; i_dev_ready = '0; i_dev_irq = '0;
    for (int k = 0; k < N_DEV; k++)
      for (int i = 0; i < 64; i++) begin
        dev_mem[k][i] = $urandom;
        ref_mem[k][i] = dev_mem[k][i];
      end
    dev_mem[0][0] = 32'h1234;
    ref_mem[0][0] = 32'h1234;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Memory-map walk-through
    do_access(32'h7F00, 1'b0, 32'h0, 4'hF, 0, irq_cur);
    do_access(32'h8004, 1'b1, 32'hAB, 4'b0001, 2, irq_cur);
    do_access(32'h8004, 1'b0, 32'h0, 4'hF, 0, irq_cur);
    do_access(32'h8100, 1'b0, 32'h0, 4'hF, 99, irq_cur);
    do_access(32'h7E08, 1'b0, 32'h0, 4'hF, 0, irq_cur);
    do_access(32'h9000, 1'b0, 32'h0, 4'hF, 0, irq_cur);
    do_access(32'h7E08, 1'b0, 32'h0, 4'hF, 0, irq_cur);
    do_access(32'h800C, 1'b0, 32'h0, 4'hF, TIMEOUT - 1, irq_cur);
    do_access(32'h7E0C, 1'b0, 32'h0, 4'hF, 0, irq_cur);

    // Interrupts: latch under mask 0, unmask, clear, set beats clear
    set_irq(3'b001);
    do_access(32'h7E00, 1'b0, 32'h0, 4'hF, 0, irq_cur);
    do_access(32'h7E04, 1'b1, 32'h1, 4'b0001, 0, irq_cur);
    do_access(32'h7E00, 1'b1, 32'h1, 4'b0001, 0, irq_cur);
    do_access(32'h7E04, 1'b1, 32'h7, 4'b0001, 0, irq_cur);
    set_irq(3'b011);
    do_access(32'h7E00, 1'b1, 32'h2, 4'b0001, 0, irq_cur);
    do_access(32'h7E00, 1'b1, 32'h4, 4'b0001, 0, 3'b111);
    do_access(32'h7E00, 1'b1, 32'h4, 4'b1110, 0, irq_cur);
    do_access(32'h7E00, 1'b0, 32'h0, 4'hF, 0, irq_cur);

    // Asynchronous reset in the middle of a device access
    @(negedge clk);
    exp_sel = 3'b100; exp_addr = '0; exp_we = 1'b0; exp_hold = -1; dev_delay = 99;
    i_cpu_req = 1'b1; i_cpu_addr = 30'h8100 >> 2; i_cpu_we = 1'b0; i_cpu_be = 4'hF;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    i_cpu_req = 1'b0;
    i_dev_irq = 3'b010;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_mask = '0; model_err = '0;
    irq_cur = 3'b010; model_pend = irq_cur; irq_prev_m = irq_cur;
    do_access(32'h7F00, 1'b0, 32'h0, 4'hF, 0, irq_cur);
    do_access(32'h7E00, 1'b0, 32'h0, 4'hF, 0, irq_cur);
    do_access(32'h7E08, 1'b0, 32'h0, 4'hF, 0, irq_cur);

    // Randomized traffic
    for (int t = 0; t < 70; t++) begin
      sel = $urandom_range(0, 9);
      wd  = $urandom;
      if (sel <= 4) begin
        a = 32'h7F00 + 32'($urandom_range(0, N_DEV - 1)) * 32'h100 + 32'($urandom_range(0, 63)) * 4;
        dly = $urandom_range(0, 9);
        dly = (dly == 0) ? 99 : (dly == 1) ? TIMEOUT - 1 : $urandom_range(0, 4);
      end else if (sel <= 7) begin
        a = 32'h7E00 + 32'($urandom_range(0, 3)) * 4;
        dly = 0;
      end else begin
        pg = $urandom_range(0, 1) ? $urandom_range(0, 'h7D) : $urandom_range('h82, 'hFFFFFF);
        a = {pg[23:0], 6'($urandom_range(0, 63)), 2'b00};
        dly = 0;
      end
      do_access(a, 1'($urandom_range(0, 1)), wd, 4'($urandom_range(0, 15)), dly,
                ($urandom_range(0, 3) == 0) ? 3'($urandom) : irq_cur);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
